mem_access_ctrl: RTL

//  Load/store sequencer directly upstream of the 16-bit word memory unit.

---
 rtl/mem_access_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of a 16-bit word memory with a registered read port.
// 32-bit accesses are split big-endian into two word cycles (high word at A, low word at A+2).
module mem_access_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_size32,
  input  logic                  req_data_sel,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*WORD_W-1:0]   req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*WORD_W-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic                  mem_e,
  output logic                  mem_we,
  output logic                  mem_data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_din,
  input  logic [WORD_W-1:0]     mem_dout
);

  typedef enum logic [2:0] {
    IDLE, WR_HI, WR_LO, RD_HI, RD_HI_CAP, RD_LO_CAP, RESP
  } state_t;

  state_t state, state_nxt;

  logic                we_q;
  logic                size32_q;
  logic                sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2*WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0]   hi_q;
  logic [2*WORD_W-1:0] rdata_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_lo;

  // Low half lives at A+2, wrapping naturally at the top of the address space.
  assign addr_lo = addr_q + ADDR_W'(2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_addr[0])  state_nxt = RESP;
          else if (req_we)  state_nxt = WR_HI;
          else              state_nxt = RD_HI;
        end
      end
      WR_HI:     state_nxt = size32_q ? WR_LO : RESP;
      WR_LO:     state_nxt = RESP;
      RD_HI:     state_nxt = RD_HI_CAP;
      RD_HI_CAP: state_nxt = size32_q ? RD_LO_CAP : RESP;
      RD_LO_CAP: state_nxt = RESP;
      RESP:      if (resp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Request fields latch only on acceptance; read data is assembled as the words return.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      size32_q <= 1'b0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hi_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size32_q <= req_size32;
            sel_q    <= req_data_sel;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_addr[0];
            rdata_q  <= '0;
          end
        end
        RD_HI_CAP: begin
          hi_q <= mem_dout;
          if (!size32_q) rdata_q <= {{WORD_W{1'b0}}, mem_dout};
        end
        RD_LO_CAP: rdata_q <= {hi_q, mem_dout};
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_e      = 1'b0;
    mem_we     = 1'b0;
    mem_data   = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      WR_HI: begin
        mem_e    = 1'b1;
        mem_we   = 1'b1;
        mem_data = sel_q;
        mem_addr = addr_q;
        mem_din  = size32_q ? wdata_q[2*WORD_W-1:WORD_W] : wdata_q[WORD_W-1:0];
      end
      WR_LO: begin
        mem_e    = 1'b1;
        mem_we   = 1'b1;
        mem_data = sel_q;
        mem_addr = addr_lo;
        mem_din  = wdata_q[WORD_W-1:0];
      end
      RD_HI: begin
        mem_e    = 1'b1;
        mem_data = sel_q;
        mem_addr = addr_q;
      end
      RD_HI_CAP: begin
        mem_e    = size32_q;
        mem_data = sel_q;
        mem_addr = size32_q ? addr_lo : addr_q;
      end
      RD_LO_CAP: begin
        mem_data = sel_q;
        mem_addr = addr_lo;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

  logic unused_we;
  assign unused_we = we_q;

endmodule
